lpif_dstrm_flit_serializer: RTL and testbench
=============================================

Name: lpif_dstrm_flit_serializer

Overview:
- Link-layer-side stage that feeds the downstream (dstrm_*) interface of the x2 asym1 full LPIF master top.
- Accepts whole flits over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each flit into 64-bit beats, one per clk_wr, driving dstrm_state/protid/data/dvalid/crc/crc_valid/valid.
- The top has no backpressure on dstrm_*, so this block absorbs all rate mismatch.

Parameters:
- FLIT_WIDTH, 256, flit payload bits; must be a multiple of 64, range 128..1024.
- FIFO_DEPTH, 4, flit entries buffered; power of two, at least 2.
- NUM_BEATS (localparam), FLIT_WIDTH/64, beats per flit.

Ports:
- clk_wr  input  1  single clock, shared with the master top.
- rst_wr  input  1  asynchronous, active-high reset.
- tx_online  input  1  link-online qualifier; connect to the same tx_online that drives the top.
- lp_state  input  4  LPIF state sideband.
- lp_protid  input  2  protocol id of the offered flit.
- lp_flit  input  FLIT_WIDTH  flit payload; beat 0 = bits [63:0].
- lp_crc  input  2  per-flit CRC bits.
- lp_valid  input  1  flit offered.
- lp_ready  output  1  flit accepted this cycle when lp_valid and lp_ready are both 1.
- dstrm_state  output  4  registered lp_state.
- dstrm_protid  output  2  protid of the flit in flight.
- dstrm_data  output  64  current beat.
- dstrm_dvalid  output  1  data beat valid.
- dstrm_crc  output  2  CRC; meaningful only with crc_valid.
- dstrm_crc_valid  output  1  high on the last beat of a flit only.
- dstrm_valid  output  1  beat valid.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently held.
- flit_count  output  16  completed flits sent (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - All outputs 0. lp_ready = 0 during reset.
  - FIFO pointers cleared, FSM = IDLE, beat counter = 0.
- lp_ready:
  - lp_ready = tx_online & ~full, where full means fifo_level == FIFO_DEPTH.
  - Does not depend on a same-cycle pop; a full FIFO refuses a push even while popping.
  - Push occurs on lp_valid & lp_ready; an entry stores {protid, crc, flit}.
- dstrm_state: registered copy of lp_state every cycle, independent of FSM and tx_online.
- FSM, IDLE:
  - dstrm_valid, dvalid and crc_valid = 0; dstrm_data holds its last value.
  - If FIFO non-empty and tx_online: pop head into the shift register, go to SEND, beat counter = 0.
- FSM, SEND (one beat per cycle, all outputs registered):
  - dstrm_valid = dvalid = 1.
  - dstrm_data = flit[beat*64 +: 64].
  - dstrm_protid = entry protid for every beat.
  - On beat NUM_BEATS-1: crc_valid = 1 and dstrm_crc = entry crc; otherwise both are 0.
  - After the last beat: if FIFO non-empty and tx_online, pop next and stay in SEND with no bubble; else go to IDLE.
- Latency: push into an empty FIFO on edge N gives beat 0 visible after edge N+2.
- Throughput: 1 flit per NUM_BEATS cycles sustained.
- tx_online drops mid-flit:
  - The current flit completes all beats; it is never truncated.
  - No new flit is launched; FIFO contents are retained.
- Reset mid-flit: outputs go to 0 immediately (async). The partial flit and FIFO contents are discarded.
- fifo_level:
  - Increments on push, decrements on pop; unchanged on simultaneous push and pop.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro LPIF_DSTRM_FLIT_CNT_EN.
- Defined: flit_count increments by 1 on each crc_valid beat, wraps 16'hFFFF -> 0, and resets to 0.
- Undefined: flit_count is tied to 16'h0 and no counter register is built.

Test Plan:
- Reset release, tx_online=1, FLIT_WIDTH=256, one flit {64'h4444..44, 64'h3333..33, 64'h2222..22, 64'h1111..11}, protid=2'b01, crc=2'b10:
  - Beats 1111.., 2222.., 3333.., 4444.. on 4 consecutive cycles starting 2 cycles after acceptance.
  - protid=01 on all four beats; crc_valid=1 with crc=10 only on the 4444 beat.
- Two flits pushed on consecutive cycles -> 8 consecutive dstrm_valid beats, no bubble, in push order; flit_count=2 with the macro defined.
- lp_valid held high for 10 flits:
  - lp_ready deasserts while fifo_level=4 and reasserts after each pop.
  - All 40 beats are delivered in order with none lost or duplicated.
- tx_online low at beat 1 of a flit with 2 flits queued:
  - Beats 2 and 3 still complete and lp_ready=0.
  - dstrm_valid stays 0 afterwards and fifo_level stays 2 until tx_online returns.
- rst_wr pulsed during beat 2:
  - All dstrm_* outputs are 0 immediately and fifo_level=0.
  - After release, a new flit serializes correctly from beat 0.
- Macro undefined -> flit_count stays 0 after 5 flits; the other behaviour is identical.

Source files
------------

// File: rtl/lpif_dstrm_flit_serializer_if.sv
// Flit handshake (lp_*) and downstream beat bus (dstrm_*) between link layer and serializer.
// master = link-layer side offering flits, slave = the serializer.
interface lpif_dstrm_flit_serializer_if #(
  parameter int FLIT_WIDTH = 256
);
  logic [3:0]            lp_state;
  logic [1:0]            lp_protid;
  logic [FLIT_WIDTH-1:0] lp_flit;
  logic [1:0]            lp_crc;
  logic                  lp_valid;
  logic                  lp_ready;

  logic [3:0]            dstrm_state;
  logic [1:0]            dstrm_protid;
  logic [63:0]           dstrm_data;
  logic                  dstrm_dvalid;
  logic [1:0]            dstrm_crc;
  logic                  dstrm_crc_valid;
  logic                  dstrm_valid;

  modport master (
    output lp_state, lp_protid, lp_flit, lp_crc, lp_valid,
    input  lp_ready,
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid
  );

  modport slave (
    input  lp_state, lp_protid, lp_flit, lp_crc, lp_valid,
    output lp_ready,
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
           dstrm_crc, dstrm_crc_valid, dstrm_valid
  );
endinterface

// File: rtl/lpif_dstrm_flit_serializer.sv
// Buffers whole flits in a small FIFO and serializes them into 64-bit dstrm beats.
// Optional flit counter enabled by defining LPIF_DSTRM_FLIT_CNT_EN.
//
// state | meaning
// IDLE  | no flit in flight; launch head entry when FIFO non-empty and tx_online
// SEND  | one beat per cycle; on last beat chain next flit with no bubble if allowed
module lpif_dstrm_flit_serializer #(
  parameter int FLIT_WIDTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic                          tx_online,
  lpif_dstrm_flit_serializer_if.slave   bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   flit_count
);

  localparam int NUM_BEATS = FLIT_WIDTH / 64;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int EW        = FLIT_WIDTH + 4;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [EW-1:0]         head;
  logic [1:0]            head_protid;
  logic [1:0]            head_crc;
  logic [FLIT_WIDTH-1:0] head_flit;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  last_beat;
  logic [FLIT_WIDTH-1:0] shreg;
  logic [1:0]            cur_protid;
  logic [1:0]            cur_crc;
  logic [BW-1:0]         beats_left;

  assign full        = (fifo_level == LW'(FIFO_DEPTH));
  assign empty       = (fifo_level == '0);
  // Ready ignores a same-cycle pop so a full FIFO never accepts.
  assign bus.lp_ready = ~rst_wr & tx_online & ~full;
  assign push        = bus.lp_valid & bus.lp_ready;
  assign last_beat   = (beats_left == '0);
  assign pop         = tx_online & ~empty & ((state == IDLE) | ((state == SEND) & last_beat));

  assign head        = mem[rd_ptr];
  assign head_protid = head[EW-1 -: 2];
  assign head_crc    = head[FLIT_WIDTH+1 -: 2];
  assign head_flit   = head[FLIT_WIDTH-1:0];

  always_ff @(posedge clk_wr) begin
    if (push) mem[wr_ptr] <= {bus.lp_protid, bus.lp_crc, bus.lp_flit};
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop & ~push) fifo_level <= fifo_level - LW'(1);
    end
  end

  // beats_left is a down-counter; terminal count 0 marks the last beat.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state               <= IDLE;
      shreg               <= '0;
      cur_protid          <= '0;
      cur_crc             <= '0;
      beats_left          <= '0;
      bus.dstrm_state     <= '0;
      bus.dstrm_protid    <= '0;
      bus.dstrm_data      <= '0;
      bus.dstrm_dvalid    <= 1'b0;
      bus.dstrm_crc       <= '0;
      bus.dstrm_crc_valid <= 1'b0;
      bus.dstrm_valid     <= 1'b0;
    end else begin
      bus.dstrm_state <= bus.lp_state;
      case (state)
        IDLE: begin
          bus.dstrm_valid     <= 1'b0;
          bus.dstrm_dvalid    <= 1'b0;
          bus.dstrm_crc_valid <= 1'b0;
          bus.dstrm_crc       <= '0;
          if (pop) begin
            shreg      <= head_flit;
            cur_protid <= head_protid;
            cur_crc    <= head_crc;
            beats_left <= BW'(NUM_BEATS - 1);
            state      <= SEND;
          end
        end
        SEND: begin
          bus.dstrm_valid     <= 1'b1;
          bus.dstrm_dvalid    <= 1'b1;
          bus.dstrm_data      <= shreg[63:0];
          bus.dstrm_protid    <= cur_protid;
          bus.dstrm_crc_valid <= last_beat;
          bus.dstrm_crc       <= last_beat ? cur_crc : 2'b00;
          if (last_beat) begin
            if (pop) begin
              shreg      <= head_flit;
              cur_protid <= head_protid;
              cur_crc    <= head_crc;
              beats_left <= BW'(NUM_BEATS - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            shreg      <= shreg >> 64;
            beats_left <= beats_left - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LPIF_DSTRM_FLIT_CNT_EN
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr)                             flit_count <= '0;
    else if ((state == SEND) && last_beat)  flit_count <= flit_count + 16'd1;
  end
`else
  assign flit_count = 16'h0;
`endif

endmodule

// File: tb/tb_lpif_dstrm_flit_serializer.sv
// Self-checking bench: exact-timing vector table, directed corner sequences and
// randomized traffic against a queue-of-beats reference model.
module tb_lpif_dstrm_flit_serializer;
  localparam int FW = 256;
  localparam int FD = 4;
  localparam int NB = FW / 64;
`ifdef LPIF_DSTRM_FLIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_wr = 1'b0;
  logic        rst_wr = 1'b0;
  logic        tx_online = 1'b1;
  logic [2:0]  fifo_level;
  logic [15:0] flit_count;

  lpif_dstrm_flit_serializer_if #(.FLIT_WIDTH(FW)) bus ();

  lpif_dstrm_flit_serializer #(.FLIT_WIDTH(FW), .FIFO_DEPTH(FD)) dut (
    .clk_wr     (clk_wr),
    .rst_wr     (rst_wr),
    .tx_online  (tx_online),
    .bus        (bus),
    .fifo_level (fifo_level),
    .flit_count (flit_count)
  );

  always #5 clk_wr = ~clk_wr;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted flit becomes NB expected beats in order.
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  protid;
    logic        last;
    logic [1:0]  crc;
  } beat_t;

  beat_t      exp_q[$];
  logic       in_flit = 1'b0;
  int         flits_done = 0;
  logic [3:0] prev_state = 4'h0;
  logic       prev_state_ok = 1'b0;
  int         full_seen = 0;

  always @(negedge clk_wr) begin
    beat_t e;
    chk("lp_ready", 64'(bus.lp_ready), 64'(!rst_wr && tx_online && (fifo_level != 3'(FD))));
    if (rst_wr) begin
      exp_q.delete();
      in_flit       = 1'b0;
      flits_done    = 0;
      prev_state_ok = 1'b0;
    end else begin
      if (prev_state_ok) chk("dstrm_state", 64'(bus.dstrm_state), 64'(prev_state));
      prev_state    = bus.lp_state;
      prev_state_ok = 1'b1;
      if (fifo_level == 3'(FD)) full_seen++;
      if (bus.dstrm_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got beat %h, expected no beat (t=%0t)", bus.dstrm_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data",   bus.dstrm_data, e.data);
          chk("beat_protid", 64'(bus.dstrm_protid), 64'(e.protid));
          chk("beat_dvalid", 64'(bus.dstrm_dvalid), 64'(1));
          chk("beat_crcv",   64'(bus.dstrm_crc_valid), 64'(e.last));
          chk("beat_crc",    64'(bus.dstrm_crc), 64'(e.last ? e.crc : 2'b00));
          in_flit = !e.last;
          if (e.last) flits_done++;
        end
      end else begin
        if (in_flit) begin
          chk("truncated", 64'(bus.dstrm_valid), 64'(1));
          in_flit = 1'b0;
        end
        chk("idle_dvalid", 64'(bus.dstrm_dvalid), 64'(0));
        chk("idle_crcv",   64'(bus.dstrm_crc_valid), 64'(0));
      end
      chk("flit_count", 64'(flit_count), 64'(CNT_EN ? 16'(flits_done) : 16'h0));
      if (bus.lp_valid && bus.lp_ready)
        for (int b = 0; b < NB; b++)
          exp_q.push_back('{data: bus.lp_flit[b*64 +: 64], protid: bus.lp_protid,
                            last: (b == NB-1), crc: bus.lp_crc});
    end
  end

  function automatic logic [FW-1:0] rnd_flit();
    logic [FW-1:0] f;
    for (int w = 0; w < FW/32; w++) f[w*32 +: 32] = $urandom;
    return f;
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic push_flit(input logic [FW-1:0] f, input logic [1:0] p, input logic [1:0] c);
    bit done = 1'b0;
    bus.lp_flit   = f;
    bus.lp_protid = p;
    bus.lp_crc    = c;
    bus.lp_valid  = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_wr);
      done = bus.lp_ready;
      @(posedge clk_wr);
      #1;
    end
    bus.lp_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got no lp_ready within 200 cycles, expected acceptance");
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_wr);
      ok = (exp_q.size() == 0) && (fifo_level == 3'd0) && !bus.dstrm_valid;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_drain: got level %0d pending beats %0d, expected 0 and 0", tag, fifo_level, exp_q.size());
    end
    @(posedge clk_wr);
    #1;
  endtask

  task automatic do_reset();
    rst_wr       = 1'b1;
    bus.lp_valid = 1'b0;
    tx_online    = 1'b1;
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr = 1'b0;
  endtask

  task automatic wait_data(input string tag, input logic [63:0] d);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_wr);
      found = bus.dstrm_valid && (bus.dstrm_data == d);
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL %s: got no beat %h within 20 cycles, expected it", tag, d);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [3:0]  st;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_data;
    logic [1:0]  e_protid;
    logic        e_cv;
    logic [1:0]  e_crc;
    logic [3:0]  e_state;
    logic [2:0]  e_level;
  } vec_t;

  function automatic vec_t mkv(logic v, logic [3:0] st, logic er, logic ev, logic [63:0] ed,
                               logic [1:0] ep, logic ecv, logic [1:0] ec, logic [3:0] es, logic [2:0] el);
    vec_t r;
    r.valid = v;  r.st = st;  r.e_ready = er;  r.e_valid = ev;  r.e_data = ed;
    r.e_protid = ep;  r.e_cv = ecv;  r.e_crc = ec;  r.e_state = es;  r.e_level = el;
    return r;
  endfunction

  initial begin
    vec_t          tbl[8];
    logic [FW-1:0] fa, fb, fc;
    int            run;
    bit            seen;

    bus.lp_valid  = 1'b0;
    bus.lp_state  = 4'h0;
    bus.lp_protid = 2'b00;
    bus.lp_crc    = 2'b00;
    bus.lp_flit   = '0;

    // Reset state, asserted asynchronously before any clock edge
    #1 rst_wr = 1'b1;
    #1;
    chk("rst_valid",  64'(bus.dstrm_valid), 64'(0));
    chk("rst_dvalid", 64'(bus.dstrm_dvalid), 64'(0));
    chk("rst_data",   bus.dstrm_data, 64'(0));
    chk("rst_protid", 64'(bus.dstrm_protid), 64'(0));
    chk("rst_crc",    64'(bus.dstrm_crc), 64'(0));
    chk("rst_crcv",   64'(bus.dstrm_crc_valid), 64'(0));
    chk("rst_state",  64'(bus.dstrm_state), 64'(0));
    chk("rst_level",  64'(fifo_level), 64'(0));
    chk("rst_fcount", 64'(flit_count), 64'(0));
    chk("rst_ready",  64'(bus.lp_ready), 64'(0));
    repeat (2) @(posedge clk_wr);
    #1 rst_wr = 1'b0;

    // Single flit, exact cycle timing
    fa = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    tbl[0] = mkv(1'b1, 4'h5, 1'b1, 1'b0, 64'h0,                 2'b00, 1'b0, 2'b00, 4'h0, 3'd0);
    tbl[1] = mkv(1'b0, 4'hA, 1'b1, 1'b0, 64'h0,                 2'b00, 1'b0, 2'b00, 4'h5, 3'd1);
    tbl[2] = mkv(1'b0, 4'h3, 1'b1, 1'b0, 64'h0,                 2'b00, 1'b0, 2'b00, 4'hA, 3'd0);
    tbl[3] = mkv(1'b0, 4'hC, 1'b1, 1'b1, 64'h1111111111111111, 2'b01, 1'b0, 2'b00, 4'h3, 3'd0);
    tbl[4] = mkv(1'b0, 4'h1, 1'b1, 1'b1, 64'h2222222222222222, 2'b01, 1'b0, 2'b00, 4'hC, 3'd0);
    tbl[5] = mkv(1'b0, 4'hF, 1'b1, 1'b1, 64'h3333333333333333, 2'b01, 1'b0, 2'b00, 4'h1, 3'd0);
    tbl[6] = mkv(1'b0, 4'h7, 1'b1, 1'b1, 64'h4444444444444444, 2'b01, 1'b1, 2'b10, 4'hF, 3'd0);
    tbl[7] = mkv(1'b0, 4'h9, 1'b1, 1'b0, 64'h4444444444444444, 2'b01, 1'b0, 2'b00, 4'h7, 3'd0);
    for (int r = 0; r < 8; r++) begin
      @(posedge clk_wr);
      #1;
      bus.lp_valid  = tbl[r].valid;
      bus.lp_state  = tbl[r].st;
      bus.lp_flit   = fa;
      bus.lp_protid = 2'b01;
      bus.lp_crc    = 2'b10;
      @(negedge clk_wr);
      chk($sformatf("tbl%0d_ready", r), 64'(bus.lp_ready), 64'(tbl[r].e_ready));
      chk($sformatf("tbl%0d_valid", r), 64'(bus.dstrm_valid), 64'(tbl[r].e_valid));
      chk($sformatf("tbl%0d_data", r),  bus.dstrm_data, tbl[r].e_data);
      chk($sformatf("tbl%0d_state", r), 64'(bus.dstrm_state), 64'(tbl[r].e_state));
      chk($sformatf("tbl%0d_level", r), 64'(fifo_level), 64'(tbl[r].e_level));
      if (tbl[r].e_valid) begin
        chk($sformatf("tbl%0d_protid", r), 64'(bus.dstrm_protid), 64'(tbl[r].e_protid));
        chk($sformatf("tbl%0d_crcv", r),   64'(bus.dstrm_crc_valid), 64'(tbl[r].e_cv));
        chk($sformatf("tbl%0d_crc", r),    64'(bus.dstrm_crc), 64'(tbl[r].e_crc));
      end
    end
    @(posedge clk_wr);
    #1 bus.lp_state = 4'h0;

    // Two flits back to back: 8 beats with no bubble
    do_reset();
    push_flit(rnd_flit(), 2'b10, 2'b01);
    push_flit(rnd_flit(), 2'b11, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_wr);
      seen = bus.dstrm_valid;
    end
    run = 0;
    while (seen && bus.dstrm_valid && run < 20) begin
      run++;
      @(negedge clk_wr);
    end
    chk("b2b_beats", 64'(run), 64'(2*NB));
    wait_idle("b2b");
    chk("b2b_fcount", 64'(flit_count), 64'(CNT_EN ? 2 : 0));

    // lp_valid held high for 10 flits: FIFO fills, nothing lost
    do_reset();
    full_seen = 0;
    for (int k = 0; k < 10; k++) push_flit(rnd_flit(), 2'(k), 2'(k+1));
    wait_idle("burst");
    chk("burst_full_seen", 64'(full_seen > 0), 64'(1));
    chk("burst_flits", 64'(flits_done), 64'(10));

    // tx_online drops at beat 1 with 2 flits queued
    do_reset();
    fa = rnd_flit();
    fb = rnd_flit();
    fc = rnd_flit();
    push_flit(fa, 2'b01, 2'b10);
    push_flit(fb, 2'b10, 2'b01);
    push_flit(fc, 2'b11, 2'b11);
    wait_data("offl_beat0", fa[63:0]);
    @(posedge clk_wr);
    #1 tx_online = 1'b0;
    for (int i = 0; i < NB-1; i++) begin
      @(negedge clk_wr);
      chk("offl_finish", 64'(bus.dstrm_valid), 64'(1));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_wr);
      chk("offl_quiet", 64'(bus.dstrm_valid), 64'(0));
      chk("offl_level", 64'(fifo_level), 64'(2));
    end
    @(posedge clk_wr);
    #1 tx_online = 1'b1;
    wait_idle("offl");
    chk("offl_flits", 64'(flits_done), 64'(3));

    // Reset pulsed during beat 2
    do_reset();
    fa = rnd_flit();
    push_flit(fa, 2'b01, 2'b01);
    push_flit(rnd_flit(), 2'b10, 2'b10);
    wait_data("rstmid_beat1", fa[127:64]);
    @(posedge clk_wr);
    #1 rst_wr = 1'b1;
    #1;
    chk("rstmid_valid",  64'(bus.dstrm_valid), 64'(0));
    chk("rstmid_dvalid", 64'(bus.dstrm_dvalid), 64'(0));
    chk("rstmid_data",   bus.dstrm_data, 64'(0));
    chk("rstmid_protid", 64'(bus.dstrm_protid), 64'(0));
    chk("rstmid_crcv",   64'(bus.dstrm_crc_valid), 64'(0));
    chk("rstmid_level",  64'(fifo_level), 64'(0));
    chk("rstmid_fcount", 64'(flit_count), 64'(0));
    @(posedge clk_wr);
    #1 rst_wr = 1'b0;
    fb = rnd_flit();
    push_flit(fb, 2'b11, 2'b10);
    wait_data("rstmid_new_beat0", fb[63:0]);
    wait_idle("rstmid");
    chk("rstmid_flits", 64'(flits_done), 64'(1));

    // Randomized traffic with random tx_online and lp_state
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk_wr);
      #1;
      bus.lp_valid  = ($urandom_range(0, 1) == 1);
      bus.lp_flit   = rnd_flit();
      bus.lp_protid = 2'($urandom);
      bus.lp_crc    = 2'($urandom);
      bus.lp_state  = 4'($urandom);
      tx_online     = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk_wr);
    #1;
    bus.lp_valid = 1'b0;
    tx_online    = 1'b1;
    wait_idle("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by t=%0t, expected $finish earlier", $time);
    $fatal(1);
  end
endmodule
